// File: rtl/vga_timing_gen.sv
// Purpose : parametrised raster timing generator (hs/vs, de, visible x/y, line/frame strobes).
// Latency : 1 enabled cycle from the hc/vc counter state to the registered outputs.
// Backpressure: pix_en=0 freezes counters and every output register (strobes stay high while held).
//
// Ports:
//   clk_vga                 pixel clock
//   rst                     synchronous active-high reset (overrides pix_en)
//   pix_en                  clock enable
//   hs, vs                  sync outputs, active level set by HS_POL / VS_POL
//   de                      visible-window flag
//   hc_visible, vc_visible  visible coordinates, forced to 0 outside the window
//   line_start              first visible pixel of each visible line
//   frame_start             visible pixel (0,0)
//   frame_cnt [15:0]        frames started since reset; present only with `define VGA_FRAME_CNT_EN
//
// Line order is sync, back porch, visible, front porch. Frames use the same order.

module vga_timing_gen #(
   parameter int H_VISIBLE = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_VISIBLE = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int CW        = 11
) (
   input  logic          clk_vga,
   input  logic          rst,
   input  logic          pix_en,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [CW-1:0] hc_visible,
   output logic [CW-1:0] vc_visible,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int H_TOTAL     = H_SYNC + H_BP + H_VISIBLE + H_FP;
   localparam int V_TOTAL     = V_SYNC + V_BP + V_VISIBLE + V_FP;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int H_ACT_END   = H_ACT_START + H_VISIBLE;
   localparam int V_ACT_START = V_SYNC + V_BP;
   localparam int V_ACT_END   = V_ACT_START + V_VISIBLE;
   localparam logic HS_ACT    = (HS_POL != 0);
   localparam logic VS_ACT    = (VS_POL != 0);

   // Every decode constant is at most TOTAL-1 (front porch >= 1), so CW bits hold them all.
   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end
   if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be >= 1");
   end

   logic [CW-1:0] r_hc;
   logic [CW-1:0] r_vc;

   logic          w_h_last;
   logic          w_v_last;
   logic          w_hsync_act;
   logic          w_vsync_act;
   logic          w_hvis;
   logic          w_vvis;
   logic          w_de;
   logic          w_line_start;

   logic          r_hs;
   logic          r_vs;
   logic          r_de;
   logic [CW-1:0] r_hc_vis;
   logic [CW-1:0] r_vc_vis;
   logic          r_line_start;
   logic          r_frame_start;

   assign w_h_last     = (r_hc == CW'(H_TOTAL - 1));
   assign w_v_last     = (r_vc == CW'(V_TOTAL - 1));
   assign w_hsync_act  = (r_hc < CW'(H_SYNC));
   assign w_vsync_act  = (r_vc < CW'(V_SYNC));
   assign w_hvis       = (r_hc >= CW'(H_ACT_START)) && (r_hc < CW'(H_ACT_END));
   assign w_vvis       = (r_vc >= CW'(V_ACT_START)) && (r_vc < CW'(V_ACT_END));
   assign w_de         = w_hvis && w_vvis;
   assign w_line_start = w_de && (r_hc == CW'(H_ACT_START));

   // Raster counters: vc advances only on the hc wrap, both wrap together at the frame end.
   always_ff @(posedge clk_vga) begin
      if (rst) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (pix_en) begin
         if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + CW'(1);
         end else begin
            r_hc <= r_hc + CW'(1);
         end
      end
   end

   // Output stage: registering the decode keeps every output glitch-free.
   always_ff @(posedge clk_vga) begin
      if (rst) begin
         r_hs          <= ~HS_ACT;
         r_vs          <= ~VS_ACT;
         r_de          <= 1'b0;
         r_hc_vis      <= '0;
         r_vc_vis      <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (pix_en) begin
         r_hs          <= w_hsync_act ? HS_ACT : ~HS_ACT;
         r_vs          <= w_vsync_act ? VS_ACT : ~VS_ACT;
         r_de          <= w_de;
         r_hc_vis      <= w_de ? r_hc - CW'(H_ACT_START) : '0;
         r_vc_vis      <= w_de ? r_vc - CW'(V_ACT_START) : '0;
         r_line_start  <= w_line_start;
         r_frame_start <= w_line_start && (r_vc == CW'(V_ACT_START));
      end
   end

   assign hs          = r_hs;
   assign vs          = r_vs;
   assign de          = r_de;
   assign hc_visible  = r_hc_vis;
   assign vc_visible  = r_vc_vis;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
   // r_wrapped marks that the counters now sit at (0,0) because of a frame wrap
   // (not because of reset), so the count bumps on the same edge that presents
   // the new frame's first sync cycle at the outputs.
   logic        r_wrapped;
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         r_wrapped   <= 1'b0;
         r_frame_cnt <= '0;
      end else if (pix_en) begin
         r_wrapped <= w_h_last && w_v_last;
         if (r_wrapped) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule
